// File: rtl/usb_bit_stuffer_pkg.sv
// Shared constants for the USB 1.x transmit path.
package usb_tx_pkg;

    localparam int   USB_MAX_ONES = 6;
    localparam logic USB_IDLE_BIT = 1'b1;
    localparam int   STUFF_CNT_W  = 16;

endpackage : usb_tx_pkg

// File: rtl/usb_bit_stuffer_if.sv
// Serial bit stream link between the serializer, the bit stuffer and the NRZI encoder.
// stuff_count only exists when USB_BIT_STUFFER_STATS_EN is defined.
interface usb_bit_stuffer_if;
    import usb_tx_pkg::*;

    logic stuff_en;
    logic bit_strobe;
    logic bit_in;
    logic bit_out;
    logic bit_out_valid;
    logic stall;
`ifdef USB_BIT_STUFFER_STATS_EN
    logic [STUFF_CNT_W-1:0] stuff_count;
`endif

    // master = upstream serializer side, slave = the stuffer itself
    modport master (
        output stuff_en,
        output bit_strobe,
        output bit_in,
        input  bit_out,
        input  bit_out_valid,
`ifdef USB_BIT_STUFFER_STATS_EN
        input  stuff_count,
`endif
        input  stall
    );

    modport slave (
        input  stuff_en,
        input  bit_strobe,
        input  bit_in,
        output bit_out,
        output bit_out_valid,
`ifdef USB_BIT_STUFFER_STATS_EN
        output stuff_count,
`endif
        output stall
    );

endinterface : usb_bit_stuffer_if

// File: rtl/usb_bit_stuffer_ones_counter.sv
// Saturating consecutive-ones counter with clear/increment controls and a terminal flag.
module usb_ones_counter
    import usb_tx_pkg::*;
#(
    parameter int MAX_ONES = USB_MAX_ONES
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam int CNT_W = $clog2(MAX_ONES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ONES);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign at_max = (cnt_reg == CNT_MAX);

endmodule : usb_ones_counter

// File: rtl/usb_bit_stuffer.sv
// USB 1.x transmit bit stuffer: inserts a 0 after MAX_ONES consecutive 1s and stalls upstream.
// Optional USB_BIT_STUFFER_STATS_EN adds a wrapping count of emitted stuffed bits.
module usb_bit_stuffer
    import usb_tx_pkg::*;
#(
    parameter int MAX_ONES = USB_MAX_ONES
) (
    input  logic                clk,
    input  logic                n_rst,
    usb_bit_stuffer_if.slave    bus
);

    logic at_max;
    logic cnt_clr;
    logic cnt_inc;
    logic stuff_now;
    logic bit_out_reg;
    logic bit_out_next;
    logic bit_out_valid_reg;

    // Count only ever reaches MAX_ONES while enabled and is cleared whenever
    // stuffing is off, so the terminal flag alone is a registered stall.
    usb_ones_counter #(
        .MAX_ONES (MAX_ONES)
    ) u_ones_counter (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .at_max (at_max)
    );

    always_comb begin
        stuff_now    = bus.bit_strobe && bus.stuff_en && at_max;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        bit_out_next = bit_out_reg;
        if (!bus.stuff_en) begin
            cnt_clr = 1'b1;
            if (bus.bit_strobe) begin
                bit_out_next = bus.bit_in;
            end
        end else if (bus.bit_strobe) begin
            if (at_max) begin
                // upstream held its bit; it is sent on the following strobe
                bit_out_next = 1'b0;
                cnt_clr      = 1'b1;
            end else if (bus.bit_in) begin
                bit_out_next = 1'b1;
                cnt_inc      = 1'b1;
            end else begin
                bit_out_next = 1'b0;
                cnt_clr      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            bit_out_reg       <= USB_IDLE_BIT;
            bit_out_valid_reg <= 1'b0;
        end else begin
            bit_out_reg       <= bit_out_next;
            bit_out_valid_reg <= bus.bit_strobe;
        end
    end

    assign bus.bit_out       = bit_out_reg;
    assign bus.bit_out_valid = bit_out_valid_reg;
    assign bus.stall         = at_max;

`ifdef USB_BIT_STUFFER_STATS_EN
    logic [STUFF_CNT_W-1:0] stuff_count_reg;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            stuff_count_reg <= '0;
        end else if (stuff_now) begin
            stuff_count_reg <= stuff_count_reg + STUFF_CNT_W'(1);
        end
    end

    assign bus.stuff_count = stuff_count_reg;
`else
    logic unused_stuff_now;
    assign unused_stuff_now = stuff_now;
`endif

endmodule : usb_bit_stuffer

// File: tb/tb_usb_bit_stuffer.sv
// Directed, table-driven bench for usb_bit_stuffer (default MAX_ONES = 6).
module tb_usb_bit_stuffer;

    logic clk = 1'b0;
    logic n_rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_stuffs = 0;

    usb_bit_stuffer_if bus ();

    usb_bit_stuffer #(.MAX_ONES(6)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en;
        logic b;
        logic exp_out;
        logic exp_stall;
        logic stuffed;
    } vec_t;

    vec_t vec_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string name);
`ifdef USB_BIT_STUFFER_STATS_EN
        chk(name, bus.stuff_count, 16'(exp_stuffs));
`endif
    endtask

    // One strobe, then two idle cycles; checks output, valid pulse, hold and stall.
    task automatic do_strobe(input logic en, input logic b, input logic exp_out,
                             input logic exp_stall, input logic stuffed, input string tag);
        bus.stuff_en   = en;
        bus.bit_in     = b;
        bus.bit_strobe = 1'b1;
        tick();
        bus.bit_strobe = 1'b0;
        bus.bit_in     = 1'b0;
        if (stuffed) exp_stuffs++;
        chk({tag, " bit_out"}, 16'(bus.bit_out), 16'(exp_out));
        chk({tag, " valid"}, 16'(bus.bit_out_valid), 16'd1);
        chk({tag, " stall"}, 16'(bus.stall), 16'(exp_stall));
        tick();
        chk({tag, " valid_drop"}, 16'(bus.bit_out_valid), 16'd0);
        chk({tag, " hold"}, 16'(bus.bit_out), 16'(exp_out));
        tick();
        $display("strobe %s en=%0b in=%0b out=%0b stall=%0b", tag, en, b, bus.bit_out, bus.stall);
    endtask

    task automatic push(input logic en, input logic b, input logic o, input logic s, input logic st);
        vec_t v;
        v.en = en; v.b = b; v.exp_out = o; v.exp_stall = s; v.stuffed = st;
        vec_q.push_back(v);
    endtask

    task automatic push_ones(input int n, input logic en);
        for (int k = 0; k < n; k++) push(en, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Six 1s, stuffed 0, then a 1 and a 0
        push_ones(5, 1'b1);
        push(1, 1, 1, 1, 0);
        push(1, 1, 0, 0, 1);
        push(1, 1, 1, 0, 0);
        push(1, 0, 0, 0, 0);
        // 1111101111110: count restarts at the embedded 0, 13th strobe is a stuff
        push_ones(5, 1'b1);
        push(1, 0, 0, 0, 0);
        push_ones(5, 1'b1);
        push(1, 1, 1, 1, 0);
        push(1, 0, 0, 0, 1);
        push(1, 0, 0, 0, 0);
        // Twelve 1s: two stuffed zeros, 14 output bits
        push_ones(5, 1'b1);
        push(1, 1, 1, 1, 0);
        push(1, 1, 0, 0, 1);
        push_ones(5, 1'b1);
        push(1, 1, 1, 1, 0);
        push(1, 1, 0, 0, 1);
        // Bypass: eight 1s pass through, no stall
        push_ones(8, 1'b0);
        // Re-enabled: six 1s then a stuff
        push_ones(5, 1'b1);
        push(1, 1, 1, 1, 0);
        push(1, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0);

        // Reset with random inputs
        n_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.stuff_en   = 1'($urandom_range(0, 1));
            bus.bit_strobe = 1'($urandom_range(0, 1));
            bus.bit_in     = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst bit_out", 16'(bus.bit_out), 16'd1);
        chk("rst valid", 16'(bus.bit_out_valid), 16'd0);
        chk("rst stall", 16'(bus.stall), 16'd0);
        chk_stats("rst stuff_count");
        bus.stuff_en = 1'b1; bus.bit_strobe = 1'b0; bus.bit_in = 1'b0;
        n_rst = 1'b0;
        tick(); tick();
        chk("idle bit_out", 16'(bus.bit_out), 16'd1);
        chk("idle valid", 16'(bus.bit_out_valid), 16'd0);
        chk("idle stall", 16'(bus.stall), 16'd0);
        $display("reset done out=%0b valid=%0b stall=%0b", bus.bit_out, bus.bit_out_valid, bus.stall);

        foreach (vec_q[i]) begin
            do_strobe(vec_q[i].en, vec_q[i].b, vec_q[i].exp_out, vec_q[i].exp_stall,
                      vec_q[i].stuffed, $sformatf("vec%0d", i));
            chk_stats($sformatf("vec%0d stuff_count", i));
        end

        // stuff_en falls while stalled: stall drops, no stuff emitted
        for (int k = 0; k < 5; k++) do_strobe(1, 1, 1, 0, 0, "pre_off");
        do_strobe(1, 1, 1, 1, 0, "pre_off6");
        bus.stuff_en = 1'b0;
        tick();
        chk("off stall_drop", 16'(bus.stall), 16'd0);
        do_strobe(0, 1, 1, 0, 0, "off_byp");
        do_strobe(1, 1, 1, 0, 0, "reen");
        chk_stats("off stuff_count");
        do_strobe(1, 0, 0, 0, 0, "reen0");

        // Mid-stream reset with five ones counted
        for (int k = 0; k < 5; k++) do_strobe(1, 1, 1, 0, 0, "pre_rst");
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        exp_stuffs = 0;
        chk("mid_rst bit_out", 16'(bus.bit_out), 16'd1);
        chk("mid_rst valid", 16'(bus.bit_out_valid), 16'd0);
        chk("mid_rst stall", 16'(bus.stall), 16'd0);
        chk_stats("mid_rst stuff_count");
        tick();
        for (int k = 0; k < 5; k++) do_strobe(1, 1, 1, 0, 0, "post_rst");
        do_strobe(1, 1, 1, 1, 0, "post_rst6");
        do_strobe(1, 1, 0, 0, 1, "post_stuff");
        chk_stats("post stuff_count");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_usb_bit_stuffer
